// File: rtl/ss_stream_to_bin_pkg.sv
// Shared definitions for the stochastic-to-binary readout: FSM states, result
// width helper and the sign encoding used by the add/sub stage.
package ss_pkg;

  typedef enum logic {
    SS_IDLE  = 1'b0,
    SS_ACCUM = 1'b1
  } ss_state_e;

  // Sign bit value that marks a negative stochastic sample.
  localparam logic SS_SIGN_NEG = 1'b1;

  // A window of 2^wb samples sums to -2^wb..+2^wb, which needs wb+2 signed bits.
  function automatic int ss_val_width(input int window_bits);
    return window_bits + 2;
  endfunction

endpackage

// File: rtl/ss_stream_to_bin_if.sv
// Stream-in / result-out bundle of ss_stream_to_bin.
interface ss_stream_to_bin_if
  import ss_pkg::*;
#(
  parameter int WINDOW_BITS = 8,
  parameter int VAL_WIDTH   = ss_val_width(WINDOW_BITS)
);

  // Handshake: START is a request that takes effect only while BUSY is low and
  // needs no acknowledge beyond BUSY rising next cycle; VALID is a one-cycle
  // strobe with no back-pressure, and VALUE/OUT_SIGN/OUT_MAG hold until the next strobe.
  logic                        START;
  logic                        CONT;
  logic                        IN;
  logic                        SIGN_IN;
  logic signed [VAL_WIDTH-1:0] VALUE;
  logic                        OUT_SIGN;
  logic [WINDOW_BITS:0]        OUT_MAG;
  logic                        VALID;
  logic                        BUSY;
  ss_state_e                   dbg_state;

  modport master (
    output START, CONT, IN, SIGN_IN,
    input  VALUE, OUT_SIGN, OUT_MAG, VALID, BUSY, dbg_state
  );

  modport slave (
    input  START, CONT, IN, SIGN_IN,
    output VALUE, OUT_SIGN, OUT_MAG, VALID, BUSY, dbg_state
  );

endinterface

// File: rtl/ss_window_counter.sv
// Sample counter for one integration window; LAST marks the final sample cycle.
module ss_window_counter #(
  parameter int WINDOW_BITS = 8
) (
  input  logic CLK,
  input  logic INIT,
  input  logic CLR,
  input  logic EN,
  output logic LAST
);

  logic [WINDOW_BITS-1:0] cnt;

  // Wraps from N-1 to 0 on its own, which gives gap-free back-to-back windows.
  always_ff @(posedge CLK) begin
    if (INIT || CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= cnt + WINDOW_BITS'(1);
    end
  end

  assign LAST = &cnt;

endmodule

// File: rtl/ss_stream_to_bin.sv
// Integrates a sign-magnitude stochastic bitstream over 2^WINDOW_BITS cycles and
// presents the signed sum, its sign and its magnitude with a one-cycle VALID.
module ss_stream_to_bin
  import ss_pkg::*;
#(
  parameter int WINDOW_BITS = 8,
  parameter int VAL_WIDTH   = ss_val_width(WINDOW_BITS)
) (
  input logic               CLK,
  input logic               INIT,
  ss_stream_to_bin_if.slave bus
);

  localparam int MAG_W = WINDOW_BITS + 1;

  ss_state_e                   state, state_nxt;
  logic                        cnt_clr, cnt_en, last;
  logic                        acc_clr, acc_en, res_load;
  logic signed [VAL_WIDTH-1:0] acc, acc_nxt, step;
  logic [MAG_W-1:0]            mag_nxt;

  ss_window_counter #(.WINDOW_BITS(WINDOW_BITS)) u_cnt (
    .CLK  (CLK),
    .INIT (INIT),
    .CLR  (cnt_clr),
    .EN   (cnt_en),
    .LAST (last)
  );

  always_comb begin
    step = '0;
    if (bus.IN) begin
      step = (bus.SIGN_IN == SS_SIGN_NEG) ? '1 : VAL_WIDTH'(1);
    end
  end

  // The last sample is folded in here, so the published result includes it.
  assign acc_nxt = acc + step;
  assign mag_nxt = acc_nxt[VAL_WIDTH-1] ? MAG_W'(-acc_nxt) : MAG_W'(acc_nxt);

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state <= SS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    res_load  = 1'b0;
    case (state)
      SS_IDLE: begin
        if (bus.START) begin
          cnt_clr   = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = SS_ACCUM;
        end
      end
      SS_ACCUM: begin
        cnt_en = 1'b1;
        if (last) begin
          res_load = 1'b1;
          acc_clr  = 1'b1;
          if (!bus.CONT) begin
            state_nxt = SS_IDLE;
          end
        end else begin
          acc_en = 1'b1;
        end
      end
      default: state_nxt = SS_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT || acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      bus.VALUE    <= '0;
      bus.OUT_SIGN <= 1'b0;
      bus.OUT_MAG  <= '0;
      bus.VALID    <= 1'b0;
    end else begin
      bus.VALID <= res_load;
      if (res_load) begin
        bus.VALUE    <= acc_nxt;
        bus.OUT_SIGN <= acc_nxt[VAL_WIDTH-1];
        bus.OUT_MAG  <= mag_nxt;
      end
    end
  end

  assign bus.BUSY      = (state == SS_ACCUM);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ss_stream_to_bin.sv
// Randomized bench for ss_stream_to_bin (N=16): window sums from sample counts,
// a timestamped expected queue and a VALID monitor.
module tb_ss_stream_to_bin;
  import ss_pkg::*;

  localparam int WB = 4;
  localparam int N  = 16;
  localparam int VW = WB + 2;

  logic clk = 1'b0;
  logic init;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic signed [VW-1:0] exp_q[$];
  int                   exp_cyc_q[$];
  logic signed [VW-1:0] mon_e;
  int                   mon_ev;
  int                   mon_ec;
  int                   last_sum;

  ss_stream_to_bin_if #(.WINDOW_BITS(WB)) bus ();

  ss_stream_to_bin #(.WINDOW_BITS(WB)) dut (
    .CLK  (clk),
    .INIT (init),
    .bus  (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every VALID must match the oldest expected window result
  always @(negedge clk) begin
    if (bus.VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        mon_ev = int'(mon_e);
        check("valid_cycle", cyc, mon_ec);
        check("value", int'(bus.VALUE), mon_ev);
        check("out_sign", int'(bus.OUT_SIGN), (mon_ev < 0) ? 1 : 0);
        check("out_mag", int'(bus.OUT_MAG), (mon_ev < 0) ? -mon_ev : mon_ev);
      end
    end
  end

  // driver: one window of npos positive, nneg negative, rest zero samples, shuffled
  task automatic run_window(input int npos, input int nneg, input bit with_start,
                            input bit cont, input bit poke_start);
    int smp[N];
    int k;
    int tmp;
    int fs;
    for (int i = 0; i < N; i++) smp[i] = (i < npos) ? 1 : ((i < npos + nneg) ? 2 : 0);
    for (int i = N - 1; i > 0; i--) begin
      k = $urandom_range(0, i);
      tmp = smp[i]; smp[i] = smp[k]; smp[k] = tmp;
    end
    if (with_start) begin
      @(posedge clk); #1;
      bus.START   = 1'b1;
      bus.IN      = 1'b1;
      bus.SIGN_IN = 1'($urandom_range(0, 1));
      bus.CONT    = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        fs = cyc;
        exp_q.push_back(VW'(npos - nneg));
        exp_cyc_q.push_back(fs + N);
      end
      check("busy_in_window", int'(bus.BUSY), 1);
      bus.START   = poke_start && (i == 5);
      bus.IN      = (smp[i] != 0);
      bus.SIGN_IN = (smp[i] == 2) ? 1'b1 : ((smp[i] == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.CONT    = cont;
    end
    last_sum = npos - nneg;
    if (!cont) begin
      @(posedge clk); #1;
      bus.IN    = 1'b0;
      bus.CONT  = 1'b0;
      bus.START = 1'b0;
      check("busy_after_window", int'(bus.BUSY), 0);
    end
  endtask

  task automatic idle_check(input int cycles, input int exp_value);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      bus.IN = 1'($urandom_range(0, 1));
      check("idle_busy", int'(bus.BUSY), 0);
      check("idle_value", int'(bus.VALUE), exp_value);
    end
    bus.IN = 1'b0;
  endtask

  initial begin
    int np, nn;
    bit cn, prev_cont;
    init        = 1'b1;
    bus.START   = 1'b0;
    bus.CONT    = 1'b0;
    bus.IN      = 1'b0;
    bus.SIGN_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    check("rst_value", int'(bus.VALUE), 0);
    check("rst_sign", int'(bus.OUT_SIGN), 0);
    check("rst_mag", int'(bus.OUT_MAG), 0);
    check("rst_valid", int'(bus.VALID), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    idle_check(20, 0);

    run_window(16, 0, 1'b1, 1'b0, 1'b0);
    run_window(10, 4, 1'b1, 1'b0, 1'b0);
    run_window(3, 9, 1'b1, 1'b0, 1'b0);
    run_window(0, 16, 1'b1, 1'b0, 1'b0);
    idle_check(3, -16);

    // continuous: +5, -3, 0
    run_window(5, 0, 1'b1, 1'b1, 1'b0);
    run_window(0, 3, 1'b0, 1'b1, 1'b0);
    run_window(4, 4, 1'b0, 1'b0, 1'b0);

    // START mid-window must not restart or stretch the window
    run_window(8, 2, 1'b1, 1'b0, 1'b1);

    // abort on the 8th sample
    @(posedge clk); #1;
    bus.START = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.START   = 1'b0;
      bus.IN      = 1'b1;
      bus.SIGN_IN = 1'b0;
      if (i == 7) init = 1'b1;
    end
    @(posedge clk); #1;
    init   = 1'b0;
    bus.IN = 1'b0;
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_value", int'(bus.VALUE), 0);
    check("abort_valid", int'(bus.VALID), 0);
    idle_check(20, 0);

    // random windows, randomly chained in continuous mode
    prev_cont = 1'b0;
    for (int w = 0; w < 8; w++) begin
      np = $urandom_range(0, N);
      nn = $urandom_range(0, N - np);
      cn = (w < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_window(np, nn, !prev_cont, cn, 1'($urandom_range(0, 1)));
      prev_cont = cn;
    end

    idle_check(20, last_sum);
    check("pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
